// File: rtl/seg_page_display_if.sv
// Bundle of channel inputs, buttons and display outputs for the paged
// seven-segment scanner. The DUT sits on the slave side.
interface seg_page_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32
);
  localparam int NUM_PAGES = (DATA_W + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     ch_btn;
  logic                     page_btn;
  logic                     blank_lz;
  logic [6:0]               seg_a2g;
  logic [NUM_DIGITS-1:0]    anode_drv;
  logic [CH_W-1:0]          ch_idx;
  logic [PG_W-1:0]          page_idx;

  modport master (
    output ch_data, ch_btn, page_btn, blank_lz,
    input  seg_a2g, anode_drv, ch_idx, page_idx
  );

  modport slave (
    input  ch_data, ch_btn, page_btn, blank_lz,
    output seg_a2g, anode_drv, ch_idx, page_idx
  );
endinterface

// File: rtl/seg_page_display.sv
// Multiplexed seven-segment viewer: scans NUM_DIGITS digits over one page of
// a frame-coherent channel snapshot, with debounced channel/page buttons.
module seg_page_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 32,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input logic               clk,
  input logic               reset,
  seg_page_display_if.slave bus
);
  localparam int NUM_PAGES = (DATA_W + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PAD_W     = NUM_PAGES * NUM_DIGITS * 4;
  localparam int NIB_W     = (NUM_PAGES * NUM_DIGITS > 1) ? $clog2(NUM_PAGES * NUM_DIGITS) : 1;

  logic [PRE_W-1:0]      preCnt;
  logic [DIG_W-1:0]      digitIdx;
  logic [DATA_W-1:0]     snapshot;
  logic                  started;
  logic [CH_W-1:0]       chIdx;
  logic [PG_W-1:0]       pageIdx;
  logic [6:0]            segReg;
  logic [NUM_DIGITS-1:0] anodeReg;

  logic [1:0]            rawBtn;
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            debLevel;
  logic [1:0]            stepPulse;
  logic [DEB_W-1:0]      debCnt [2];

  logic                  tick;
  logic                  lastDigit;
  logic                  loadSnap;
  logic [PAD_W-1:0]      padded;
  logic [NIB_W-1:0]      nibIdx;
  logic [3:0]            nibble;
  logic                  upperZero;
  logic                  blankNow;

  function automatic logic [6:0] hexToSeg(input logic [3:0] v);
    case (v)
      4'h0: hexToSeg = 7'h40;
      4'h1: hexToSeg = 7'h79;
      4'h2: hexToSeg = 7'h24;
      4'h3: hexToSeg = 7'h30;
      4'h4: hexToSeg = 7'h19;
      4'h5: hexToSeg = 7'h12;
      4'h6: hexToSeg = 7'h02;
      4'h7: hexToSeg = 7'h78;
      4'h8: hexToSeg = 7'h00;
      4'h9: hexToSeg = 7'h10;
      4'hA: hexToSeg = 7'h08;
      4'hB: hexToSeg = 7'h03;
      4'hC: hexToSeg = 7'h46;
      4'hD: hexToSeg = 7'h21;
      4'hE: hexToSeg = 7'h06;
      default: hexToSeg = 7'h0E;
    endcase
  endfunction

  assign rawBtn    = {bus.page_btn, bus.ch_btn};
  assign tick      = (preCnt == PRE_W'(REFRESH_DIV - 1));
  assign lastDigit = (digitIdx == DIG_W'(NUM_DIGITS - 1));
  // The very first edge after reset counts as a frame wrap so the display never shows stale zeros long.
  assign loadSnap  = !started || (tick && lastDigit);
  assign padded    = PAD_W'(snapshot);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preCnt   <= '0;
      digitIdx <= '0;
      snapshot <= '0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (tick) begin
        preCnt   <= '0;
        digitIdx <= lastDigit ? '0 : digitIdx + 1'b1;
      end else begin
        preCnt <= preCnt + 1'b1;
      end
      if (loadSnap) snapshot <= bus.ch_data[chIdx*DATA_W +: DATA_W];
    end
  end

  // Index 0 is the channel button, index 1 the page button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      debLevel  <= '0;
      stepPulse <= '0;
      for (int b = 0; b < 2; b++) debCnt[b] <= '0;
    end else begin
      sync1 <= rawBtn;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        stepPulse[b] <= 1'b0;
        if (sync2[b] != debLevel[b]) begin
          if (debCnt[b] == DEB_W'(DEBOUNCE_CYC - 1)) begin
            debLevel[b]  <= sync2[b];
            debCnt[b]    <= '0;
            stepPulse[b] <= sync2[b];
          end else begin
            debCnt[b] <= debCnt[b] + 1'b1;
          end
        end else begin
          debCnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chIdx   <= '0;
      pageIdx <= '0;
    end else if (stepPulse[0]) begin
      chIdx   <= (chIdx == CH_W'(NUM_CH - 1)) ? '0 : chIdx + 1'b1;
      pageIdx <= '0;
    end else if (stepPulse[1]) begin
      pageIdx <= (pageIdx == PG_W'(NUM_PAGES - 1)) ? '0 : pageIdx + 1'b1;
    end
  end

  always_comb begin
    nibIdx    = NIB_W'(pageIdx) * NIB_W'(NUM_DIGITS) + NIB_W'(digitIdx);
    nibble    = padded[{nibIdx, 2'b00} +: 4];
    upperZero = ((padded >> {nibIdx, 2'b00}) == '0);
    blankNow  = bus.blank_lz && (nibIdx != '0) && upperZero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      segReg   <= '1;
      anodeReg <= '1;
    end else if (blankNow) begin
      segReg   <= '1;
      anodeReg <= '1;
    end else begin
      segReg   <= hexToSeg(nibble);
      anodeReg <= ~(NUM_DIGITS'(1) << digitIdx);
    end
  end

  assign bus.seg_a2g   = segReg;
  assign bus.anode_drv = anodeReg;
  assign bus.ch_idx    = chIdx;
  assign bus.page_idx  = pageIdx;
endmodule

// File: tb/tb_seg_page_display.sv
// Bench for seg_page_display: directed scenarios plus random button/data
// traffic, checked every cycle against a frame/page/debounce reference model.
module tb_seg_page_display;
  localparam int ND    = 4;
  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int RDIV  = 4;
  localparam int DEB   = 8;
  localparam int NPAGE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   clkEn = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] hexOn [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, as seen after the most recent clock edge.
  int              edgeNum;
  logic [DW-1:0]   mSnap;
  int              mCh, mPage, mDigit;
  bit              h1 [2];
  bit              h2 [2];
  bit              deb [2];
  int              run [2];
  bit              pend [2];
  logic [NCH*DW-1:0] curData;

  seg_page_display_if #(.NUM_DIGITS(ND), .NUM_CH(NCH), .DATA_W(DW)) bus ();

  seg_page_display #(
    .NUM_DIGITS(ND), .NUM_CH(NCH), .DATA_W(DW),
    .REFRESH_DIV(RDIV), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH*DW-1:0] data, input bit blank, input bit chB, input bit pgB);
    curData      = data;
    bus.ch_data  = data;
    bus.blank_lz = blank;
    bus.ch_btn   = chB;
    bus.page_btn = pgB;
  endtask

  function automatic void expDisplay(input logic [DW-1:0] snap, input int page, input int digit,
                                     input bit blank, output logic [3:0] an, output logic [6:0] sg);
    int         n;
    logic [63:0] sh;
    logic [3:0] nib;
    n   = page * ND + digit;
    sh  = {32'b0, snap} >> (4 * n);
    nib = (4 * n < DW) ? sh[3:0] : 4'h0;
    if (blank && n != 0 && sh == 64'd0) begin
      an = 4'hF;
      sg = 7'h7F;
    end else begin
      an = 4'hF;
      an[digit] = 1'b0;
      sg = ~hexOn[nib];
    end
  endfunction

  task automatic modelReset();
    edgeNum = 0;
    mSnap   = '0;
    mCh     = 0;
    mPage   = 0;
    mDigit  = 0;
    for (int b = 0; b < 2; b++) begin
      h1[b] = 0; h2[b] = 0; deb[b] = 0; run[b] = 0; pend[b] = 0;
    end
  endtask

  task automatic tick();
    bit               raw [2];
    bit               s;
    bit               blankNow;
    logic [NCH*DW-1:0] dataNow;
    logic [3:0]       ean;
    logic [6:0]       esg;
    raw[0]   = bus.ch_btn;
    raw[1]   = bus.page_btn;
    dataNow  = bus.ch_data;
    blankNow = bus.blank_lz;
    @(posedge clk);
    #1;
    edgeNum++;
    expDisplay(mSnap, mPage, mDigit, blankNow, ean, esg);
    if (edgeNum == 1 || edgeNum % (RDIV * ND) == 0) mSnap = dataNow[mCh*DW +: DW];
    mDigit = (edgeNum / RDIV) % ND;
    if (pend[0]) begin
      mCh   = (mCh + 1) % NCH;
      mPage = 0;
    end else if (pend[1]) begin
      mPage = (mPage + 1) % NPAGE;
    end
    // Synchroniser modelled as a two-sample delay; a level is accepted after DEB differing samples in a row.
    for (int b = 0; b < 2; b++) begin
      pend[b] = 0;
      s     = h2[b];
      h2[b] = h1[b];
      h1[b] = raw[b];
      if (s != deb[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          deb[b]  = s;
          run[b]  = 0;
          pend[b] = s;
        end
      end else begin
        run[b] = 0;
      end
    end
    checkOutput("anode", bus.anode_drv, ean);
    checkOutput("seg", bus.seg_a2g, esg);
    checkOutput("ch_idx", bus.ch_idx, mCh);
    checkOutput("page_idx", bus.page_idx, mPage);
  endtask

  task automatic runCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_anode", bus.anode_drv, 4'hF);
    checkOutput("rst_seg", bus.seg_a2g, 7'h7F);
    checkOutput("rst_ch", bus.ch_idx, 0);
    checkOutput("rst_page", bus.page_idx, 0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] seg_page_display bench start");
    applyStimulus({$urandom, 32'h1234ABCD}, 1'b0, 1'b0, 1'b0);
    #12;
    doReset();

    // Scan order D, C, B, A on page 0.
    runCycles(2);
    checkOutput("req032_anode", bus.anode_drv, 4'b1110);
    checkOutput("req032_seg", bus.seg_a2g, 7'h21);
    runCycles(30);

    // Long press steps the page exactly once.
    applyStimulus(curData, 1'b0, 1'b0, 1'b1);
    runCycles(20);
    applyStimulus(curData, 1'b0, 1'b0, 1'b0);
    runCycles(20);
    checkOutput("req033_page", bus.page_idx, 1);

    // Bounce shorter than the debounce window is ignored.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(curData, 1'b0, 1'b0, (i % 2) == 0);
      runCycles(3);
    end
    applyStimulus(curData, 1'b0, 1'b0, 1'b0);
    runCycles(12);
    checkOutput("req034_page", bus.page_idx, 1);

    // Channel step resets the page; new data waits for the next frame.
    applyStimulus({32'hCAFE0001, curData[31:0]}, 1'b0, 1'b1, 1'b0);
    runCycles(14);
    applyStimulus(curData, 1'b0, 1'b0, 1'b0);
    runCycles(24);
    checkOutput("req035_ch", bus.ch_idx, 1);
    checkOutput("req035_page", bus.page_idx, 0);

    // Leading-zero blanking with a mostly empty word.
    applyStimulus({32'hCAFE0001, 32'h000000F0}, 1'b1, 1'b1, 1'b0);
    runCycles(14);
    applyStimulus(curData, 1'b1, 1'b0, 1'b0);
    runCycles(30);
    applyStimulus(curData, 1'b1, 1'b0, 1'b1);
    runCycles(14);
    applyStimulus(curData, 1'b1, 1'b0, 1'b0);
    runCycles(30);
    checkOutput("req036_page", bus.page_idx, 1);
    runCycles(1);
    checkOutput("req036_anode", bus.anode_drv, 4'hF);
    checkOutput("req036_seg", bus.seg_a2g, 7'h7F);

    // Both buttons together act as a channel step.
    applyStimulus(curData, 1'b0, 1'b1, 1'b1);
    runCycles(14);
    applyStimulus(curData, 1'b0, 1'b0, 1'b0);
    runCycles(20);
    checkOutput("simul_ch", bus.ch_idx, 1);
    checkOutput("simul_page", bus.page_idx, 0);

    for (int r = 0; r < 14; r++) begin
      applyStimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      runCycles($urandom_range(1, 14));
      applyStimulus(curData, bus.blank_lz, 1'b0, 1'b0);
      runCycles($urandom_range(1, 14));
      if (r % 4 == 3) applyStimulus({curData[63:32], 32'h00000000 | 32'($urandom_range(0, 255))}, 1'b1, 1'b0, 1'b0);
      runCycles($urandom_range(4, 20));
    end
    runCycles(16);

    // Press cut short by reset must not step anything.
    applyStimulus(curData, 1'b0, 1'b0, 1'b1);
    runCycles(5);
    applyStimulus(curData, 1'b0, 1'b0, 1'b0);
    doReset();
    runCycles(20);
    checkOutput("req031_page", bus.page_idx, 0);

    // Reset with the clock frozen mid-scan.
    runCycles(7);
    clkEn = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    checkOutput("req037_anode", bus.anode_drv, 4'b1111);
    checkOutput("req037_seg", bus.seg_a2g, 7'b1111111);
    #10;
    clkEn = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    runCycles(24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_page_display.md
SEG_PAGE_DISPLAY -- requirements
Module: seg_page_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of seven-segment digits scanned.
REQ-002 SHALL have parameter NUM_CH, default 2, number of selectable DATA_W-bit source channels.
REQ-003 SHALL have parameter DATA_W, default 32, width of each channel; NUM_PAGES = ceil(DATA_W / (4*NUM_DIGITS)).
REQ-004 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot.
REQ-005 SHALL have parameter DEBOUNCE_CYC, default 500000, stable-input cycles required to accept a button level.
REQ-006 clk  input  1  sole clock, all state rising-edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ch_data  input  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-009 ch_btn  input  1  raw push button, steps channel.
REQ-010 page_btn  input  1  raw push button, steps page.
REQ-011 blank_lz  input  1  leading-zero blanking enable.
REQ-012 seg_a2g  output  7  segments a..g, bit 0 = a, active-low, registered.
REQ-013 anode_drv  output  NUM_DIGITS  digit enables, active-low, bit i = digit i (digit 0 rightmost), registered.
REQ-014 ch_idx  output  clog2(NUM_CH) (min 1)  current channel.
REQ-015 page_idx  output  clog2(NUM_PAGES) (min 1)  current page.

Function
REQ-016 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count digit index SHALL advance, NUM_DIGITS-1 wrapping to 0.
REQ-017 Snapshot register SHALL load ch_data of channel ch_idx on the cycle digit index wraps to 0; display SHALL use only the snapshot (frame-coherent).
REQ-018 Digit i on page p SHALL show global nibble n = p*NUM_DIGITS + i, i.e. snapshot[4n+3:4n]; nibble bits beyond DATA_W SHALL read 0.
REQ-019 Each button SHALL pass a 2-flop synchroniser, then a counter; debounced level SHALL update only after DEBOUNCE_CYC consecutive cycles of the synchronised level differing from it; any mismatch-free interruption SHALL clear the counter.
REQ-020 Debounced rising edge SHALL produce exactly one one-cycle step pulse; falling edge none.
REQ-021 Channel step SHALL set ch_idx = (ch_idx+1) mod NUM_CH and page_idx = 0.
REQ-022 Page step SHALL set page_idx = (page_idx+1) mod NUM_PAGES.
REQ-023 Simultaneous channel and page step SHALL behave as channel step only (page_idx = 0).
REQ-024 With blank_lz = 1, digit SHALL be blanked when its nibble n and all nibbles above n up to the top of DATA_W are zero; nibble 0 SHALL never be blanked. With blank_lz = 0 no blanking.
REQ-025 Blanked slot SHALL drive anode_drv all ones and seg_a2g = 7'b1111111.
REQ-026 Non-blanked slot SHALL drive anode_drv low on bit i only and seg_a2g = hex decode of the nibble (0-F, lowercase b,d).
REQ-027 seg_a2g/anode_drv SHALL update one cycle after digit index changes; never two anodes low simultaneously.
REQ-028 ch_idx/page_idx SHALL update the cycle after the step pulse; new channel data SHALL appear only after the next snapshot.

Reset
REQ-029 reset low SHALL immediately, without clk, force anode_drv all ones, seg_a2g all ones, prescaler, digit index, ch_idx, page_idx, snapshot, synchronisers, debounce counters and debounced levels to 0.
REQ-030 After reset release, first snapshot SHALL load on the first clk edge (digit index 0 treated as wrap).
REQ-031 Reset mid-scan or mid-debounce SHALL discard partial counts; no step pulse SHALL issue from a press interrupted by reset.

Verification (NUM_DIGITS=4, NUM_CH=2, DATA_W=32, REFRESH_DIV=4, DEBOUNCE_CYC=8)
REQ-032 ch0=32'h1234ABCD, release reset -> anode_drv 4'b1110, seg_a2g = decode(D); every 4 cycles digits 1,2,3 show C,B,A, then wrap.
REQ-033 page_btn held high 20 cycles -> single step, page_idx=1 about 10 cycles after press; digits 0..3 show 4,3,2,1.
REQ-034 page_btn toggled every 3 cycles for 30 cycles -> no step, page_idx unchanged.
REQ-035 page_idx=1, ch1=32'hCAFE0001, ch_btn press -> ch_idx=1, page_idx=0, digit 0 shows 1 only after next scan wrap.
REQ-036 blank_lz=1, ch0=32'h000000F0 -> page 0: digits 3,2 blanked, digit 1 F, digit 0 0; page 1: all four blanked.
REQ-037 reset asserted mid-scan with clk stopped -> anode_drv=4'b1111, seg_a2g=7'b1111111 immediately.
